// File: rtl/huffman_encoder.sv
// Fixed-table prefix encoder: 8-bit symbol -> {4-bit length, 12-bit LSB-aligned codeword}.
// One symbol per enabled clock, single output register, no backpressure.
module huffman_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  data_in,
  output logic [15:0] data_out
);

  localparam int unsigned SYM_W  = 8;
  localparam int unsigned LEN_W  = 4;
  localparam int unsigned CODE_W = 12;
  localparam int unsigned OUT_W  = LEN_W + CODE_W;

  logic [LEN_W-1:0]  len_c;
  logic [CODE_W-1:0] code_c;
  logic [SYM_W-1:0]  off_c;

  // Class is picked by the highest set bit group; offsets keep the subtraction in range.
  always_comb begin
    len_c  = 4'd0;
    code_c = 12'd0;
    off_c  = 8'd0;
    if (data_in[7:6] != 2'b00) begin
      off_c  = data_in - 8'd64;
      len_c  = 4'd11;
      code_c = {1'b0, 3'b111, off_c};
    end else if (data_in[5:4] != 2'b00) begin
      off_c  = data_in - 8'd16;
      len_c  = 4'd9;
      code_c = {3'b000, 3'b110, 6'(off_c)};
    end else if (data_in[3:2] != 2'b00) begin
      off_c  = data_in - 8'd4;
      len_c  = 4'd6;
      code_c = {6'b000000, 2'b10, 4'(off_c)};
    end else begin
      len_c  = 4'd3;
      code_c = {9'd0, 1'b0, data_in[1:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= OUT_W'(0);
    end else if (enable) begin
      data_out <= {len_c, code_c};
    end
  end

endmodule

// File: tb/tb_huffman_encoder.sv
// Directed bench for huffman_encoder: reset, stream, class boundaries, hold,
// async reset, and a full symbol sweep against an independent model.
module tb_huffman_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  data_in;
  logic [15:0] data_out;

  int total = 0;
  int bad   = 0;

  huffman_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #50 clk = ~clk;

  function automatic logic [15:0] model(input int s);
    int len;
    int code;
    if (s < 4)       begin len = 3;  code = s; end
    else if (s < 16) begin len = 6;  code = 32 + (s - 4); end
    else if (s < 64) begin len = 9;  code = 384 + (s - 16); end
    else             begin len = 11; code = 1792 + (s - 64); end
    return 16'((len << 12) | code);
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    total++;
    assert (data_out === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, data_out, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present a symbol at the falling edge; result is checked one falling edge later.
  task automatic enc(input logic [7:0] s, input logic [15:0] exp, input string tag);
    data_in = s;
    enable  = 1'b1;
    @(negedge clk);
    chk(tag, exp);
  endtask

  logic [15:0] words [256];

  initial begin
    int viol;
    int li, lj;
    int len_bad, hi_bad;

    rst = 1'b1; enable = 1'b0; data_in = 8'd0;
    #1;
    chk("reset_async", 16'h0000);
    repeat (2) @(negedge clk);
    chk("reset_held", 16'h0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_idle", 16'h0000);

    enc(8'd5,   16'h6021, "s5");
    enc(8'd68,  16'hB704, "s68");
    enc(8'd50,  16'h91A2, "s50");
    enc(8'd100, 16'hB724, "s100");
    enc(8'd150, 16'hB756, "s150");
    enc(8'd200, 16'hB788, "s200");
    enc(8'd250, 16'hB7BA, "s250");
    enc(8'd255, 16'hB7BF, "s255");

    enable = 1'b0; data_in = 8'd100;
    repeat (10) @(negedge clk);
    chk("hold_100", 16'hB7BF);
    data_in = 8'd255;
    repeat (10) @(negedge clk);
    chk("hold_255", 16'hB7BF);
    enc(8'd100, 16'hB724, "resume_100");

    enc(8'd0,  16'h3000, "bnd0");
    enc(8'd3,  16'h3003, "bnd3");
    enc(8'd4,  16'h6020, "bnd4");
    enc(8'd15, 16'h602B, "bnd15");
    enc(8'd16, 16'h9180, "bnd16");
    enc(8'd63, 16'h91AF, "bnd63");
    enc(8'd64, 16'hB700, "bnd64");

    // Pulse reset between edges while a symbol is pending.
    data_in = 8'd200;
    @(posedge clk);
    #20 rst = 1'b1;
    #5 chk("midreset_clear", 16'h0000);
    #10 rst = 1'b0;
    @(negedge clk);
    chk("midreset_lost", 16'h0000);
    enc(8'd5, 16'h6021, "after_reset");

    len_bad = 0; hi_bad = 0;
    for (int s = 0; s < 256; s++) begin
      enc(8'(s), model(s), "sweep");
      words[s] = data_out;
      li = int'(data_out[15:12]);
      if (!(li == 3 || li == 6 || li == 9 || li == 11)) len_bad++;
      else if ((int'(data_out[11:0]) >> li) != 0) hi_bad++;
    end
    chk_int("sweep_len_set", len_bad, 0);
    chk_int("sweep_high_zero", hi_bad, 0);

    viol = 0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        li = int'(words[i][15:12]);
        lj = int'(words[j][15:12]);
        if (i != j && li <= lj && li > 0 &&
            (int'(words[j][11:0]) >> (lj - li)) == int'(words[i][11:0]))
          viol++;
      end
    end
    chk_int("prefix_free", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/huffman_encoder.md
Name: huffman_encoder

Overview:
Registered fixed-table prefix (Huffman-style) encoder. It maps each 8-bit input symbol to a variable-length codeword of 3, 6, 9 or 11 bits. The output is a 16-bit word that packs the codeword length and the codeword, and a downstream bit packer/serializer consumes it. There is one symbol per enabled clock and no backpressure.

Parameters:
None. All widths are fixed: 8-bit symbol, 16-bit output, 4-bit length field, 12-bit code field.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  when 1, the symbol on data_in is encoded on the next rising edge; when 0, the output holds
data_in  input  8  symbol to encode, unsigned 0..255
data_out  output  16  registered result: [15:12] codeword length in bits; [11:0] codeword, LSB-aligned

Behaviour:
- Reset: rst=1 asynchronously forces data_out=16'h0000 and holds it while asserted. The first update after release happens on the first rising edge with rst=0 and enable=1.
- Latency: 1 clock. On a rising edge with enable=1, data_out takes encode(data_in) sampled at that edge.
- enable=0: data_out keeps its last value indefinitely; data_in changes are ignored.
- Back-to-back: a new symbol every cycle is supported; each enabled edge fully replaces data_out.
- Code table, where s = data_in and the MSB of the codeword is sent first:
  - Class A, s=0..3: prefix "0" + s[1:0]; length 3.
  - Class B, s=4..15: prefix "10" + (s-4) as 4 bits; length 6.
  - Class C, s=16..63: prefix "110" + (s-16) as 6 bits; length 9.
  - Class D, s=64..255: prefix "111" + (s-64) as 8 bits; length 11.
- Class boundaries are exact: 3/4, 15/16 and 63/64 change class.
- The code set is prefix-free by construction; no symbol is unencodable.
- data_out[11:0] holds the codeword right-aligned. Bits at and above position "length" within [11:0] are 0.
- data_out[15:12] holds the length: 3, 6, 9 or 11. Length 0 (all-zero word) appears only after reset with no enabled edge yet, and marks "no valid code".
- Subtractions are unsigned and in range by class selection. The upper bits of (s-offset) beyond the field width are always 0 and are discarded.
- The encoder is purely combinational from data_in, followed by a single 16-bit register. It has no other state.
- X/undefined data_in sampled while enable=1 yields an undefined data_out; there is no requirement on it.
- Reset asserted mid-stream clears data_out immediately, independent of the clock. A pending symbol is lost.

Test Plan:
- Reset: rst=1 for 2 cycles with enable=0 → data_out=16'h0000 during and after reset; it stays 0 until the first enabled edge.
- Stream with enable=1, 1 symbol per 100 ns clock, each checked 1 cycle later:
  - 5→16'h6021, 68→16'hB704, 50→16'h91A2, 100→16'hB724
  - 150→16'hB756, 200→16'hB788, 250→16'hB7BA, 255→16'hB7BF
- Class boundaries:
  - 0→16'h3000, 3→16'h3003
  - 4→16'h6020, 15→16'h602B
  - 16→16'h9180, 63→16'h91AF
  - 64→16'hB700
- Hold: after encoding 255 (16'hB7BF), drop enable and drive data_in=100, then 255, for ≥10 cycles each → data_out stays 16'hB7BF. Re-raise enable with data_in=100 → 16'hB724 one cycle later.
- Async reset mid-stream: while streaming, pulse rst between clock edges → data_out goes to 16'h0000 before the next edge. After release, the next enabled symbol encodes normally.
- Exhaustive sweep s=0..255 with enable=1 against a reference model:
  - length field ∈ {3,6,9,11}
  - code bits above the length are zero
  - no codeword is a prefix of another
